mig_traffic_gen: RTL and testbench
==================================

# mig_traffic_gen

Parametrised traffic generator and checker for the MIG 7-series user (app_*) interface. Writes a programmable number of data beats at a strided address sequence, reads them back, and compares each returned beat against a regenerated pattern, reporting error count, first failing address and read timeout. Sits between the board-level top and the MIG core in the `ui_clk` domain. Replaces the fixed 10-beat write/read bring-up sequencer with a run-time-configurable, self-checking engine.

## Interface
- ADDR_WIDTH, 29: app_addr width.
- DATA_WIDTH, 256: app data width; multiple of 32.
- CNT_WIDTH, 16: beat-count width.
- ADDR_STRIDE, 8: address increment per beat.
- TIMEOUT, 1024: max idle cycles waiting for read data.
- ui_clk  in  1  clock; all logic on rising edge.
- ui_clk_sync_rst  in  1  reset, synchronous, active-high.
- init_calib_complete  in  1  MIG calibration done.
- start  in  1  one-cycle run request.
- mode  in  2  0 write+check, 1 write only, 2 check only, 3 treated as 0.
- num_beats  in  CNT_WIDTH  beats per run.
- base_addr  in  ADDR_WIDTH  first address.
- seed  in  32  pattern seed.
- app_addr  out  ADDR_WIDTH; app_cmd  out  3 (000 write, 001 read); app_en  out  1.
- app_wdf_data  out  DATA_WIDTH; app_wdf_wren  out  1; app_wdf_end  out  1 (= app_wdf_wren); app_wdf_mask  out  DATA_WIDTH/8 (all zero).
- app_rdy, app_wdf_rdy  in  1; app_rd_data  in  DATA_WIDTH; app_rd_data_valid  in  1.
- busy  out  1; done  out  1 (level, held until next start); error  out  1 (sticky per run).
- err_count  out  CNT_WIDTH (saturating); first_err_addr  out  ADDR_WIDTH; timeout  out  1.

## Operation
- start, mode, num_beats, base_addr, seed latched only when start=1 in IDLE or DONE; start ignored while busy.
- Latching clears done, error, err_count, first_err_addr, timeout and all indices.
- States: IDLE -> WAIT_CAL (until init_calib_complete) -> WRITE (modes 0,1) or READ (mode 2) -> DRAIN (reads only) -> DONE. WRITE -> READ (mode 0) or DONE (mode 1) once num_beats commands accepted. READ -> DRAIN once num_beats read commands accepted; DRAIN -> DONE when all num_beats beats received or timeout.
- num_beats=0: WAIT_CAL -> DONE, no app_en/app_wdf_wren asserted, error=0.
- Address of beat k: base_addr + k*ADDR_STRIDE mod 2^ADDR_WIDTH (wraps silently).
- Pattern beat k: 32-bit lane j = seed + k + j mod 2^32.
- Write: data index wd and command index wc independent. app_wdf_wren=1 while wd<num_beats; beat accepted when app_wdf_wren & app_wdf_rdy. app_en=1 with cmd write while wc<wd, or wc==wd and data accepted same cycle; accepted when app_en & app_rdy. app_en, app_addr, app_cmd held stable until accepted; likewise app_wdf_data.
- Read: app_en=1, cmd read, addr of beat rc, advance on app_rdy. Returned beats in order; return index rr selects expected pattern.
- Compare: mismatch -> error=1, err_count+1 (saturate at all-ones), first_err_addr=addr(rr) on first mismatch only.
- app_rd_data_valid when rr==num_beats or outside READ/DRAIN: counted as mismatch, first_err_addr unchanged if already set.
- Timeout: counter resets on each valid beat or read accept; reaching TIMEOUT in READ/DRAIN with rr<rc sets timeout=1, error=1, -> DONE.

## Timing
- All outputs registered. Reset values: app_en=0, app_wdf_wren=0, app_cmd=000, app_addr=0, app_wdf_data=0, busy=0, done=0, error=0, err_count=0, first_err_addr=0, timeout=0; state IDLE.
- Reset mid-run aborts at next edge; no further commands issued.
- start at cycle t (calibrated) -> busy=1 at t+1, first app_en/app_wdf_wren at t+2.
- With app_rdy and app_wdf_rdy held high: one write per cycle, num_beats writes in num_beats cycles; one read command per cycle.
- Compare result (error/err_count) updates one cycle after app_rd_data_valid.
- done=1 and busy=0 one cycle after last beat compared or timeout.

## Test plan
- Mode 0, num_beats=10, base_addr=0, seed=0, always ready -> writes at 0,8..72, lane0 data 0..9, reads return written data, err_count=0, done=1.
- Random app_rdy/app_wdf_rdy throttling, num_beats=100 -> exactly 100 writes, no command before its data, stable app_addr while stalled, err_count=0.
- Mode 2, memory model corrupts beats 3 and 7 -> err_count=2, first_err_addr=base_addr+24.
- Mode 0, memory drops last read beat, TIMEOUT=16 -> timeout=1, error=1, done within 17 cycles of last valid beat.
- base_addr=2^29-16, num_beats=4 -> addresses 2^29-16, 2^29-8, 0, 8.
- num_beats=0 -> done=1, no app_en; reset asserted mid-WRITE -> all outputs at reset values next edge.

Source files
------------

// File: rtl/mig_traffic_gen_if.sv
// MIG 7-series app_* user-interface bundle.
// The generator drives it through master; the memory controller side uses slave.
interface mig_traffic_gen_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256
) ();
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                    app_rdy;
  logic                    app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   app_rd_data;
  logic                    app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/mig_traffic_gen.sv
// Write/read-back traffic generator and checker for the MIG app_* interface.
// Beat k lives at base + k*ADDR_STRIDE; each 32-bit lane j of beat k carries seed + k + j.
module mig_tg_lane #(
  parameter int LANE      = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic [31:0]          seed,
  input  logic [CNT_WIDTH-1:0] wr_idx,
  input  logic [CNT_WIDTH-1:0] rd_idx,
  input  logic [31:0]          rd_word,
  output logic [31:0]          wr_word,
  output logic                 mismatch
);
  localparam logic [31:0] LaneOfs = 32'(LANE);

  assign wr_word  = seed + 32'(wr_idx) + LaneOfs;
  assign mismatch = rd_word != (seed + 32'(rd_idx) + LaneOfs);
endmodule

module mig_traffic_gen #(
  parameter int ADDR_WIDTH  = 29,
  parameter int DATA_WIDTH  = 256,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_STRIDE = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           seed,
  mig_traffic_gen_if.master     app,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);
  localparam int NUM_LANES = DATA_WIDTH / 32;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [1:0]            mode;
    logic [CNT_WIDTH-1:0]  nbeats;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           seed;
  } run_cfg_t;

  state_e                 state_q, state_d;
  run_cfg_t               cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0]   wd_q, wd_d, wc_q, wc_d, rc_q, rc_d, rr_q, rr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   app_en_q, app_en_d;
  logic [2:0]             app_cmd_q, app_cmd_d;
  logic [ADDR_WIDTH-1:0]  app_addr_q, app_addr_d;
  logic                   wren_q, wren_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   busy_q, busy_d, done_q, done_d, error_q, error_d, timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]  first_err_addr_q, first_err_addr_d;
  logic                   finish;

  logic                   wr_acc, cmd_acc, rd_vld, in_rd, rd_mismatch;
  logic [CNT_WIDTH-1:0]   wd_nxt, wc_nxt, rc_nxt;
  logic [NUM_LANES-1:0][31:0] wr_pat, rd_word;
  logic [NUM_LANES-1:0]   lane_mis;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] b,
                                                    input logic [CNT_WIDTH-1:0]  k);
    return b + ADDR_WIDTH'(k) * ADDR_WIDTH'(ADDR_STRIDE);
  endfunction

  assign wr_acc  = wren_q & app.app_wdf_rdy;
  assign cmd_acc = app_en_q & app.app_rdy;
  assign rd_vld  = app.app_rd_data_valid;
  assign in_rd   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign wd_nxt  = wd_q + CNT_WIDTH'(wr_acc);
  assign wc_nxt  = wc_q + CNT_WIDTH'(cmd_acc && state_q == S_WRITE);
  assign rc_nxt  = rc_q + CNT_WIDTH'(cmd_acc && state_q == S_READ);
  assign rd_word = app.app_rd_data;

  // Write pattern tracks the next data index so wdf_data is ready the cycle after acceptance.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    mig_tg_lane #(.LANE(j), .CNT_WIDTH(CNT_WIDTH)) u_lane (
      .seed     (cfg_q.seed),
      .wr_idx   (wd_nxt),
      .rd_idx   (rr_q),
      .rd_word  (rd_word[j]),
      .wr_word  (wr_pat[j]),
      .mismatch (lane_mis[j])
    );
  end
  assign rd_mismatch = |lane_mis;

  always_comb begin
    state_d          = state_q;
    cfg_d            = cfg_q;
    wd_d             = wd_q;
    wc_d             = wc_q;
    rc_d             = rc_q;
    rr_d             = rr_q;
    tmo_d            = tmo_q;
    app_en_d         = app_en_q;
    app_cmd_d        = app_cmd_q;
    app_addr_d       = app_addr_q;
    wren_d           = wren_q;
    wdata_d          = wdata_q;
    busy_d           = busy_q;
    done_d           = done_q;
    error_d          = error_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    timeout_d        = timeout_q;
    finish           = 1'b0;

    // Every returned beat is scored; beats nobody asked for count as errors too.
    if (rd_vld) begin
      if (!in_rd || rr_q == cfg_q.nbeats || rd_mismatch) begin
        error_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        if (err_count_q == '0) first_err_addr_d = addr_of(cfg_q.base, rr_q);
      end
      if (in_rd && rr_q != cfg_q.nbeats) rr_d = rr_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d          = S_WAIT_CAL;
          cfg_d.mode       = (mode == 2'd3) ? 2'd0 : mode;
          cfg_d.nbeats     = num_beats;
          cfg_d.base       = base_addr;
          cfg_d.seed       = seed;
          wd_d             = '0;
          wc_d             = '0;
          rc_d             = '0;
          rr_d             = '0;
          tmo_d            = '0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          error_d          = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          timeout_d        = 1'b0;
        end
      end
      S_WAIT_CAL: begin
        if (init_calib_complete) begin
          if (cfg_q.nbeats == '0) begin
            finish = 1'b1;
          end else if (cfg_q.mode == 2'd2) begin
            state_d    = S_READ;
            app_en_d   = 1'b1;
            app_cmd_d  = CMD_RD;
            app_addr_d = addr_of(cfg_q.base, '0);
          end else begin
            state_d = S_WRITE;
            wren_d  = 1'b1;
            wdata_d = wr_pat;
          end
        end
      end
      S_WRITE: begin
        // A command is only raised once its data beat has been taken by the MIG.
        wd_d       = wd_nxt;
        wc_d       = wc_nxt;
        wren_d     = wd_nxt < cfg_q.nbeats;
        wdata_d    = wr_pat;
        app_en_d   = wc_nxt < wd_nxt;
        app_cmd_d  = CMD_WR;
        app_addr_d = addr_of(cfg_q.base, wc_nxt);
        if (wc_nxt == cfg_q.nbeats) begin
          if (cfg_q.mode == 2'd0) begin
            state_d    = S_READ;
            app_en_d   = 1'b1;
            app_cmd_d  = CMD_RD;
            app_addr_d = addr_of(cfg_q.base, '0);
            tmo_d      = '0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      S_READ: begin
        rc_d       = rc_nxt;
        app_en_d   = rc_nxt < cfg_q.nbeats;
        app_cmd_d  = CMD_RD;
        app_addr_d = addr_of(cfg_q.base, rc_nxt);
        if (rc_nxt == cfg_q.nbeats) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rr_d == cfg_q.nbeats) finish = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle time only counts while read data is actually owed.
    if (in_rd) begin
      if (rd_vld || cmd_acc) begin
        tmo_d = '0;
      end else if (rr_q < rc_q) begin
        if (tmo_q == TmoLast) begin
          timeout_d = 1'b1;
          error_d   = 1'b1;
          finish    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end

    if (finish) begin
      state_d  = S_DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      app_en_d = 1'b0;
      wren_d   = 1'b0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q          <= S_IDLE;
      cfg_q            <= '0;
      wd_q             <= '0;
      wc_q             <= '0;
      rc_q             <= '0;
      rr_q             <= '0;
      tmo_q            <= '0;
      app_en_q         <= 1'b0;
      app_cmd_q        <= CMD_WR;
      app_addr_q       <= '0;
      wren_q           <= 1'b0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cfg_q            <= cfg_d;
      wd_q             <= wd_d;
      wc_q             <= wc_d;
      rc_q             <= rc_d;
      rr_q             <= rr_d;
      tmo_q            <= tmo_d;
      app_en_q         <= app_en_d;
      app_cmd_q        <= app_cmd_d;
      app_addr_q       <= app_addr_d;
      wren_q           <= wren_d;
      wdata_q          <= wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      timeout_q        <= timeout_d;
    end
  end

  assign app.app_en       = app_en_q;
  assign app.app_cmd      = app_cmd_q;
  assign app.app_addr     = app_addr_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_mask = '0;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_count        = err_count_q;
  assign first_err_addr   = first_err_addr_q;
  assign timeout          = timeout_q;
endmodule

// File: tb/tb_mig_traffic_gen.sv
// Randomized bench for mig_traffic_gen: a behavioural MIG memory with throttling,
// corruption and dropped beats, scored against arithmetic address/pattern rules.
module tb_mig_traffic_gen;
  localparam int AW = 29, DW = 256, CW = 16, STRIDE = 8, TMO = 16, NL = DW / 32;

  logic clk = 1'b0, rst = 1'b1, calib = 1'b0, start = 1'b0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] nbeats = '0;
  logic [AW-1:0] base = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, error, timeout;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  mig_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app_if ();

  mig_traffic_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
                    .ADDR_STRIDE(STRIDE), .TIMEOUT(TMO)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib), .start(start),
    .mode(mode), .num_beats(nbeats), .base_addr(base), .seed(seed), .app(app_if),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int due; } rd_t;

  int vecs = 0, errs = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] wq [$];
  rd_t rq [$];
  int cyc = 0, nwr, nrd, en_cycles, wren_cycles, exp_err, last_v;
  int corrupt_a = -1, corrupt_b = -1, drop_idx = -1;
  bit throttle = 0, stray = 0, prev_stall = 0;
  logic [AW-1:0] r_base, exp_first, prev_addr;
  logic [31:0]   r_seed;
  logic [2:0]    prev_cmd;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] b, input int k);
    longint unsigned a;
    a = longint'(b) + longint'(k) * STRIDE;
    return a[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_pat(input logic [31:0] s, input int k);
    logic [DW-1:0] v;
    for (int j = 0; j < NL; j++) v[j*32 +: 32] = s + 32'(k) + 32'(j);
    return v;
  endfunction

  // One cycle: drive memory-side inputs at the falling edge, then score what the
  // next rising edge will see.
  task automatic step();
    rd_t e;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    app_if.app_rdy     = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
    app_if.app_wdf_rdy = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
    app_if.app_rd_data_valid = 1'b0;
    if (stray) begin
      app_if.app_rd_data_valid = 1'b1;
      app_if.app_rd_data = {NL{$urandom}};
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      app_if.app_rd_data_valid = 1'b1;
      app_if.app_rd_data = e.data;
      last_v = cyc;
    end
    if (rst) begin
      wq.delete(); rq.delete(); prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      chk("en_hold", app_if.app_en, 1);
      chk("addr_hold", app_if.app_addr, prev_addr);
      chk("cmd_hold", app_if.app_cmd, prev_cmd);
    end
    if (app_if.app_en) en_cycles++;
    if (app_if.app_wdf_wren) wren_cycles++;
    if (app_if.app_wdf_wren && app_if.app_wdf_rdy) wq.push_back(app_if.app_wdf_data);
    if (app_if.app_en && app_if.app_rdy) begin
      if (app_if.app_cmd == 3'b000) begin
        chk("wr_data_before_cmd", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          d = wq.pop_front();
          chk("wr_addr", app_if.app_addr, ref_addr(r_base, nwr));
          chk("wr_data", d, ref_pat(r_seed, nwr));
          mem[app_if.app_addr] = d;
        end
        nwr++;
      end else begin
        chk("rd_cmd", app_if.app_cmd, 3'b001);
        chk("rd_addr", app_if.app_addr, ref_addr(r_base, nrd));
        d = mem.exists(app_if.app_addr) ? mem[app_if.app_addr] : '0;
        if (nrd == corrupt_a || nrd == corrupt_b) d[5] = ~d[5];
        if (nrd != drop_idx) begin
          if (d != ref_pat(r_seed, nrd)) begin
            exp_err++;
            if (exp_err == 1) exp_first = ref_addr(r_base, nrd);
          end
          e.data = d;
          e.due  = cyc + int'($urandom_range(1, 3));
          rq.push_back(e);
        end
        nrd++;
      end
    end
    prev_stall = app_if.app_en && !app_if.app_rdy;
    prev_addr  = app_if.app_addr;
    prev_cmd   = app_if.app_cmd;
  endtask

  task automatic begin_run(input int md, input int nb, input logic [AW-1:0] b,
                           input logic [31:0] s, input bit thr);
    r_base = b; r_seed = s; throttle = thr;
    nwr = 0; nrd = 0; en_cycles = 0; wren_cycles = 0; exp_err = 0; exp_first = '0;
    mode = 2'(md); nbeats = CW'(nb); base = b; seed = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run(input string nm, input int md, input int nb, input logic [AW-1:0] b,
                     input logic [31:0] s, input bit thr, input int ca, input int cb, input bit drop);
    int eff, budget;
    eff = (md == 3) ? 0 : md;
    corrupt_a = ca; corrupt_b = cb; drop_idx = drop ? nb - 1 : -1;
    begin_run(md, nb, b, s, thr);
    chk({nm, ":busy_t1"}, busy, 1);
    step();
    if (nb > 0) chk({nm, ":issue_t2"}, (eff == 2) ? app_if.app_en : app_if.app_wdf_wren, 1);
    budget = 0;
    while (!done && budget < 4000) begin step(); budget++; end
    chk({nm, ":done"}, done, 1);
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":writes"}, nwr, (eff != 2) ? nb : 0);
    chk({nm, ":reads"}, nrd, (eff != 1) ? nb : 0);
    chk({nm, ":rd_drained"}, rq.size(), 0);
    chk({nm, ":err_count"}, err_count, exp_err);
    chk({nm, ":error"}, error, (exp_err > 0) || drop);
    chk({nm, ":timeout"}, timeout, drop);
    chk({nm, ":first_err_addr"}, first_err_addr, exp_first);
    if (nb == 0) chk({nm, ":no_traffic"}, en_cycles + wren_cycles, 0);
    if (drop) chk({nm, ":tmo_latency"}, (cyc - last_v) <= TMO + 1, 1);
    corrupt_a = -1; corrupt_b = -1; drop_idx = -1;
  endtask

  initial begin
    app_if.app_rdy = 1'b0; app_if.app_wdf_rdy = 1'b0;
    app_if.app_rd_data = '0; app_if.app_rd_data_valid = 1'b0;
    repeat (3) step();
    chk("rst:app_en", app_if.app_en, 0);
    chk("rst:wren", app_if.app_wdf_wren, 0);
    chk("rst:cmd", app_if.app_cmd, 0);
    chk("rst:addr", app_if.app_addr, 0);
    chk("rst:wdata", app_if.app_wdf_data, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:error", error, 0);
    chk("rst:err_count", err_count, 0);
    chk("rst:first_err", first_err_addr, 0);
    chk("rst:timeout", timeout, 0);
    rst = 1'b0; calib = 1'b1;
    step();

    run("basic", 0, 10, '0, '0, 0, -1, -1, 0);
    run("throttle", 0, 100, AW'($urandom), $urandom, 1, -1, -1, 0);
    run("wr_only", 1, 10, AW'('h1000), 32'h55, 0, -1, -1, 0);
    run("corrupt", 2, 10, AW'('h1000), 32'h55, 0, 3, 7, 0);
    run("drop", 0, 10, AW'($urandom), $urandom, 0, -1, -1, 1);
    run("wrap", 0, 4, AW'((1 << AW) - 16), $urandom, 0, -1, -1, 0);
    run("zero", 0, 0, AW'($urandom), $urandom, 0, -1, -1, 0);
    run("mode3", 3, 12, AW'($urandom), $urandom, 1, -1, -1, 0);

    stray = 1; step(); stray = 0; step();
    chk("stray:err_count", err_count, 1);
    chk("stray:error", error, 1);

    repeat (4) run("rand", int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
                   AW'($urandom), $urandom, 1'($urandom_range(0, 1)), -1, -1, 0);

    begin_run(0, 100, AW'($urandom), $urandom, 1);
    repeat (20) step();
    rst = 1'b1;
    step();
    chk("midrst:app_en", app_if.app_en, 0);
    chk("midrst:wren", app_if.app_wdf_wren, 0);
    chk("midrst:addr", app_if.app_addr, 0);
    chk("midrst:wdata", app_if.app_wdf_data, 0);
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done, 0);
    rst = 1'b0;
    en_cycles = 0; wren_cycles = 0;
    repeat (10) step();
    chk("midrst:quiet", en_cycles + wren_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
